// File: rtl/nms_pkg.sv
// Shared definitions for the non-maximum suppression stage.
package nms_pkg;

    localparam int DEF_IMG_W = 1024;
    localparam int DEF_IMG_H = 768;
    localparam int DEF_MAG_W = 12;

    // Quantised gradient direction codes
    localparam logic [1:0] DIR_0   = 2'b00;
    localparam logic [1:0] DIR_45  = 2'b01;
    localparam logic [1:0] DIR_90  = 2'b10;
    localparam logic [1:0] DIR_135 = 2'b11;

    typedef enum logic [1:0] {
        IDLE,
        FILL,
        RUN,
        FLUSH
    } state_t;

endpackage

// File: rtl/nms_stage_if.sv
// Pixel stream into the NMS stage and suppressed magnitude stream out of it.
interface nms_stage_if #(
    parameter int MAG_W = 12
);
    logic             en;
    logic             in_ready;
    logic [MAG_W-1:0] mag_in;
    logic [1:0]       dir_in;
    logic [MAG_W-1:0] val_aft_nms;
    logic             nms_vld;
    logic             nms_last;

    modport master (
        output en, mag_in, dir_in,
        input  in_ready, val_aft_nms, nms_vld, nms_last
    );

    modport slave (
        input  en, mag_in, dir_in,
        output in_ready, val_aft_nms, nms_vld, nms_last
    );
endinterface

// File: rtl/nms_linebuf.sv
// One image line of storage: simple dual-port RAM with a registered,
// read-first output so a same-address write returns the previous line.
module nms_linebuf #(
    parameter int DEPTH = 1024,
    parameter int WIDTH = 14
) (
    input  logic                     clk,
    input  logic                     we,
    input  logic [$clog2(DEPTH)-1:0] waddr,
    input  logic [WIDTH-1:0]         wdata,
    input  logic                     re,
    input  logic [$clog2(DEPTH)-1:0] raddr,
    output logic [WIDTH-1:0]         rdata
);
    logic [WIDTH-1:0] mem [DEPTH];

    // Write and registered read; contents are never cleared
    always_ff @(posedge clk) begin
        if (we) mem[waddr] <= wdata;
        if (re) rdata <= mem[raddr];
    end
endmodule

// File: rtl/nms_stage.sv
// Canny non-maximum suppression: 3x3 window from two line buffers, keeps the
// centre magnitude only when it is a maximum along its gradient direction.
module nms_stage
    import nms_pkg::*;
#(
    parameter int IMG_W = DEF_IMG_W,
    parameter int IMG_H = DEF_IMG_H,
    parameter int MAG_W = DEF_MAG_W
) (
    input  logic        clk,
    input  logic        rst_n,
    nms_stage_if.slave  bus
);
    localparam int PIX_W  = MAG_W + 2;
    localparam int CW     = $clog2(IMG_W);
    localparam int RW     = $clog2(IMG_H);
    localparam int FW     = $clog2(IMG_W + 1);
    localparam int STAGES = 2;
    localparam logic [CW-1:0] COL_LAST = CW'(IMG_W - 1);
    localparam logic [RW-1:0] ROW_LAST = RW'(IMG_H - 1);
    localparam logic [FW-1:0] FL_LAST  = FW'(IMG_W);

    state_t state_q, state_d;
    logic rdy, acc, flush, beat, emit;
    logic [CW-1:0] col_q, ocol_q, c_col_q, addr, b_wa_q;
    logic [RW-1:0] row_q, orow_q, c_row_q;
    logic [FW-1:0] fcnt_q;
    logic b_we_q;
    logic [PIX_W-1:0] wdata, a_rd, b_rd;
    logic [STAGES:1] vld_pipe, last_pipe;
    logic [MAG_W-1:0] val_q, nms_val;

    // Window: t_* top row (r-2), m_* middle row (r-1), bo_* bottom row (r).
    // Right column is live: b_rd, a_rd, cur_q. Only the centre keeps its dir.
    logic [MAG_W-1:0] cur_q, t_l, t_m, m_l, bo_l, bo_m;
    logic [PIX_W-1:0] m_m;
    logic [MAG_W-1:0] cm, n1, n2;
    logic [1:0]       cd;
    logic             border;
    logic             unused_b_dir;

    assign unused_b_dir = ^b_rd[PIX_W-1:MAG_W];

    // Handshake, beat generation and next-state logic
    always_comb begin
        state_d = state_q;
        rdy     = (state_q != FLUSH) && rst_n;
        flush   = (state_q == FLUSH);
        acc     = bus.en && rdy;
        beat    = acc || flush;
        emit    = (acc && state_q == RUN) || flush;
        case (state_q)
            IDLE:    if (acc) state_d = FILL;
            FILL:    if (acc && row_q == RW'(1) && col_q == '0) state_d = RUN;
            RUN:     if (acc && row_q == ROW_LAST && col_q == COL_LAST) state_d = FLUSH;
            FLUSH:   if (fcnt_q == FL_LAST) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Flush beats walk the columns again with zero data to drain the last row
    assign addr  = flush ? ((fcnt_q == FL_LAST) ? '0 : fcnt_q[CW-1:0]) : col_q;
    assign wdata = flush ? '0 : {bus.dir_in, bus.mag_in};

    nms_linebuf #(.DEPTH(IMG_W), .WIDTH(PIX_W)) u_lb_a (
        .clk(clk), .we(beat), .waddr(addr), .wdata(wdata),
        .re(beat), .raddr(addr), .rdata(a_rd)
    );

    // B is written one cycle late with A's registered old entry
    nms_linebuf #(.DEPTH(IMG_W), .WIDTH(PIX_W)) u_lb_b (
        .clk(clk), .we(b_we_q), .waddr(b_wa_q), .wdata(a_rd),
        .re(beat), .raddr(addr), .rdata(b_rd)
    );

    // Control state, position counters and output pipeline
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            col_q     <= '0;
            row_q     <= '0;
            ocol_q    <= '0;
            orow_q    <= '0;
            c_col_q   <= '0;
            c_row_q   <= '0;
            fcnt_q    <= '0;
            b_we_q    <= 1'b0;
            b_wa_q    <= '0;
            vld_pipe  <= '0;
            last_pipe <= '0;
            val_q     <= '0;
        end else begin
            state_q <= state_d;
            if (acc) begin
                col_q <= (col_q == COL_LAST) ? '0 : col_q + 1'b1;
                if (col_q == COL_LAST) row_q <= (row_q == ROW_LAST) ? '0 : row_q + 1'b1;
            end
            fcnt_q <= flush ? fcnt_q + 1'b1 : '0;
            b_we_q <= beat;
            b_wa_q <= addr;
            if (emit) begin
                c_col_q <= ocol_q;
                c_row_q <= orow_q;
                ocol_q  <= (ocol_q == COL_LAST) ? '0 : ocol_q + 1'b1;
                if (ocol_q == COL_LAST) orow_q <= (orow_q == ROW_LAST) ? '0 : orow_q + 1'b1;
            end
            vld_pipe  <= {vld_pipe[1], emit};
            last_pipe <= {last_pipe[1], emit && orow_q == ROW_LAST && ocol_q == COL_LAST};
            val_q     <= vld_pipe[1] ? nms_val : '0;
        end
    end

    // Window shift once per beat; holds across input gaps
    always_ff @(posedge clk) begin
        if (beat) begin
            cur_q <= flush ? '0 : bus.mag_in;
            t_l   <= t_m;
            t_m   <= b_rd[MAG_W-1:0];
            m_l   <= m_m[MAG_W-1:0];
            m_m   <= a_rd;
            bo_l  <= bo_m;
            bo_m  <= cur_q;
        end
    end

    // Neighbour select by centre direction, border mask and keep rule
    always_comb begin
        cm = m_m[MAG_W-1:0];
        cd = m_m[PIX_W-1:MAG_W];
        n1 = t_l;
        n2 = cur_q;
        case (cd)
            DIR_0:   begin n1 = m_l;              n2 = a_rd[MAG_W-1:0]; end
            DIR_45:  begin n1 = b_rd[MAG_W-1:0];  n2 = bo_l;            end
            DIR_90:  begin n1 = t_m;              n2 = bo_m;            end
            default: begin n1 = t_l;              n2 = cur_q;           end
        endcase
        border  = (c_row_q == '0) || (c_row_q == ROW_LAST) ||
                  (c_col_q == '0) || (c_col_q == COL_LAST);
        nms_val = (!border && cm >= n1 && cm >= n2) ? cm : '0;
    end

    assign bus.in_ready    = rdy;
    assign bus.val_aft_nms = val_q;
    assign bus.nms_vld     = vld_pipe[STAGES];
    assign bus.nms_last    = last_pipe[STAGES];
endmodule

// File: tb/tb_nms_stage.sv
// Directed scoreboard bench for nms_stage on an 8x6 image.
module tb_nms_stage;
    import nms_pkg::*;

    localparam int W = 8;
    localparam int H = 6;
    localparam int N = W * H;

    typedef struct packed {
        logic [11:0] v;
        logic        l;
    } exp_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    nms_stage_if #(.MAG_W(12)) bus();

    nms_stage #(.IMG_W(W), .IMG_H(H), .MAG_W(12)) dut (
        .clk(clk),
        .rst_n(rst_n),
        .bus(bus)
    );

    exp_t        exp_q[$];
    logic [11:0] obs_q[$];
    logic [11:0] ref_q[$];
    int          last_q[$];
    int          fm [H][W];
    logic [1:0]  fd [H][W];
    int          n_cmp = 0;
    int          n_mis = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        n_cmp++;
        assert (obs === exp_v) else begin
            n_mis++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp_v);
        end
    endtask

    // Reference NMS computed straight from the frame arrays
    function automatic int exp_pix(input int r, input int c);
        int m, a, b;
        if (r == 0 || r == H - 1 || c == 0 || c == W - 1) return 0;
        m = fm[r][c];
        case (fd[r][c])
            2'd0:    begin a = fm[r][c-1];   b = fm[r][c+1];   end
            2'd1:    begin a = fm[r-1][c+1]; b = fm[r+1][c-1]; end
            2'd2:    begin a = fm[r-1][c];   b = fm[r+1][c];   end
            default: begin a = fm[r-1][c-1]; b = fm[r+1][c+1]; end
        endcase
        return (m >= a && m >= b) ? m : 0;
    endfunction

    task automatic set_pat(input int id);
        for (int r = 0; r < H; r++)
            for (int c = 0; c < W; c++) begin
                case (id)
                    0: begin fm[r][c] = 100; fd[r][c] = 2'd0; end
                    1: begin fm[r][c] = (r == 2 && c == 3) ? 500 : 10; fd[r][c] = 2'd0; end
                    2: begin fm[r][c] = c * 10; fd[r][c] = 2'd0; end
                    3: begin fm[r][c] = c * 10; fd[r][c] = 2'd2; end
                    4, 5: begin
                        fm[r][c] = (r == 3 && c == 3) ? 200 : (r == 2 && c == 4) ? 250 : 0;
                        fd[r][c] = (r == 3 && c == 3) ? ((id == 4) ? 2'd1 : 2'd3) : 2'd0;
                    end
                    default: begin fm[r][c] = int'($urandom_range(0, 4095)); fd[r][c] = 2'($urandom_range(0, 3)); end
                endcase
            end
    endtask

    task automatic push_exp();
        exp_t e;
        for (int k = 0; k < N; k++) begin
            e.v = 12'(exp_pix(k / W, k % W));
            e.l = (k == N - 1);
            exp_q.push_back(e);
        end
    endtask

    task automatic send_pixel(input int r, input int c, input bit gap);
        int g = 0;
        if (gap) begin bus.en = 1'b0; @(posedge clk); #1; end
        bus.mag_in = 12'(fm[r][c]);
        bus.dir_in = fd[r][c];
        bus.en     = 1'b1;
        while (!bus.in_ready && g < 100) begin @(posedge clk); #1; g++; end
        check("ready_wait", 32'(g < 100), 1);
        @(posedge clk); #1;
    endtask

    task automatic send_frame(input bit gap);
        int low = 0;
        push_exp();
        for (int k = 0; k < N; k++) send_pixel(k / W, k % W, gap && k != 0);
        bus.en = 1'b0;
        while (!bus.in_ready && low < 50) begin @(posedge clk); #1; low++; end
        check("flush_low_cycles", low, 9);
    endtask

    task automatic drain();
        int g = 0;
        while (exp_q.size() != 0 && g < 100) begin @(posedge clk); g++; end
        check("drain", exp_q.size(), 0);
        @(posedge clk); #1;
    endtask

    task automatic run_frame(input int id, input bit gap);
        set_pat(id);
        obs_q.delete();
        last_q.delete();
        send_frame(gap);
        drain();
        check("out_count", obs_q.size(), N);
    endtask

    // Output monitor: pops the scoreboard on every valid beat
    always @(negedge clk) begin : mon
        exp_t e;
        if (bus.nms_vld === 1'b1) begin
            obs_q.push_back(bus.val_aft_nms);
            if (bus.nms_last === 1'b1) last_q.push_back(obs_q.size());
            if (exp_q.size() == 0) check("unexpected_out", 1, 0);
            else begin
                e = exp_q.pop_front();
                check("pix", bus.val_aft_nms, e.v);
                check("last", bus.nms_last, e.l);
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        bus.en = 1'b0;
        bus.mag_in = '0;
        bus.dir_in = '0;
        repeat (2) @(posedge clk);
        #1;
        check("rst_in_ready", bus.in_ready, 0);
        check("rst_vld", bus.nms_vld, 0);
        check("rst_val", bus.val_aft_nms, 0);
        check("rst_last", bus.nms_last, 0);
        rst_n = 1'b1;
        #1;
        check("idle_in_ready", bus.in_ready, 1);
        @(posedge clk); #1;

        run_frame(0, 1'b0);
        check("flat_interior", obs_q[9], 100);
        check("flat_corner", obs_q[0], 0);
        check("flat_right_border", obs_q[15], 0);
        check("flat_last_count", last_q.size(), 1);
        check("flat_last_index", last_q[0], 48);

        run_frame(1, 1'b0);
        check("peak", obs_q[19], 500);
        check("peak_left", obs_q[18], 0);
        check("peak_right", obs_q[20], 0);
        check("peak_other", obs_q[11], 10);

        run_frame(2, 1'b0);
        check("ramp_dir0", obs_q[11], 0);
        run_frame(3, 1'b0);
        check("ramp_dir90", obs_q[11], 30);

        run_frame(4, 1'b0);
        check("diag_45", obs_q[27], 0);
        run_frame(5, 1'b0);
        check("diag_135", obs_q[27], 200);

        run_frame(6, 1'b0);
        ref_q = obs_q;
        obs_q.delete();
        last_q.delete();
        send_frame(1'b1);
        set_pat(1);
        send_frame(1'b0);
        drain();
        check("b2b_count", obs_q.size(), 2 * N);
        for (int i = 0; i < N; i++) check("stall_vs_ref", obs_q[i], ref_q[i]);
        check("f2_first", obs_q[N], 0);
        check("f2_peak", obs_q[N + 19], 500);
        check("b2b_last_count", last_q.size(), 2);
        check("b2b_last_1", last_q[0], 48);
        check("b2b_last_2", last_q[1], 96);

        set_pat(6);
        obs_q.delete();
        push_exp();
        for (int k = 0; k < 20; k++) send_pixel(k / W, k % W, 1'b0);
        rst_n = 1'b0;
        bus.en = 1'b0;
        #1;
        check("midrst_in_ready", bus.in_ready, 0);
        @(posedge clk); #1;
        check("midrst_vld", bus.nms_vld, 0);
        check("midrst_state", dut.state_q, IDLE);
        exp_q.delete();
        rst_n = 1'b1;
        @(posedge clk); #1;
        run_frame(6, 1'b0);
        check("post_rst_last", last_q.size(), 1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
        $finish;
    end
endmodule
